// File: rtl/uart_pkg.sv
// Shared UART definitions: default FIFO sizing and the status-register view of a FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Default TX FIFO depth used when the peripheral instantiates uart_tx_fifo.
  localparam int UART_TX_FIFO_DEPTH = 16;

  // FIFO flags in the order they are mapped into the peripheral status register.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the writing edge; read is combinational.
// Backpressure: none; the owner decides when writes are legal.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata combinational read port.
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  // Contents are deliberately not reset; occupancy is tracked by the owner.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter, with level and sticky error status.
// Latency: a byte written at edge N is on rd_data (empty=0) right after edge N; pops take effect at the next edge.
// Backpressure: writes at full are dropped (overflow) unless a pop happens in the same cycle; pops at empty are ignored (underflow).
// Ports: clk, rst_n (async, active low); wr_en/wr_data host write; rd_en/rd_data transmitter pop;
//        empty/full/almost_full/count level status; flush sync clear; overflow/underflow sticky, err_clr clears them.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = UART_TX_FIFO_DEPTH,  // power of 2, >= 4
  parameter int AFULL_THRESH = DEPTH - 2,           // 1..DEPTH
  parameter int WIDTH        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   flush,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_status_t  status_q, status_d;

  logic wr_acc;
  logic rd_acc;

  always_comb begin
    // At full, a same-cycle pop frees the slot the write lands in.
    wr_acc   = wr_en & (~status_q.full | rd_en) & ~flush;
    rd_acc   = rd_en & ~status_q.empty & ~flush;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Level flags come from the post-update count so they are pure registers on the outputs.
    status_d             = status_q;
    status_d.empty       = (count_d == '0);
    status_d.full        = (count_d == CW'(DEPTH));
    status_d.almost_full = (count_d >= CW'(AFULL_THRESH));
    // A new error in the same cycle as err_clr wins; flush suppresses error detection.
    status_d.overflow    = (wr_en & status_q.full & ~rd_en & ~flush)
                         | (status_q.overflow & ~err_clr);
    status_d.underflow   = (rd_en & status_q.empty & ~flush)
                         | (status_q.underflow & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      status_q <= '{empty: 1'b1, full: 1'b0, almost_full: 1'b0, overflow: 1'b0, underflow: 1'b0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign empty       = status_q.empty;
  assign full        = status_q.full;
  assign almost_full = status_q.almost_full;
  assign overflow    = status_q.overflow;
  assign underflow   = status_q.underflow;
  assign count       = count_q;

endmodule
